// File: rtl/countdown_timer.sv
// countdown_timer: two-digit BCD countdown timer with seven-segment output.
// Loads a preset from switches, counts down once every TICK_DIV clocks while
// running, stops at 00 and raises done.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   load         async input; rising edge loads preset (clamped to 9)
//   start        async input; rising edge toggles start/pause
//   preset_tens  BCD tens digit to load
//   preset_ones  BCD ones digit to load
//   seg0         ones digit, active-low, bit0=A .. bit6=G
//   seg1         tens digit, active-low, bit0=A .. bit6=G
//   done         high while in DONE
//   running      high while in RUN
module countdown_timer #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned DIV_W    = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    output logic [6:0] seg0,
    output logic [6:0] seg1,
    output logic       done,
    output logic       running
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state, state_n;
    logic [3:0]       tens, tens_n, ones, ones_n;
    logic [DIV_W-1:0] div, div_n;

    // Two-flop synchronizers followed by one delay flop for edge detection.
    logic load_s1, load_s2, load_d;
    logic start_s1, start_s2, start_d;
    logic load_ev, start_ev;

    assign load_ev  = load_s2  & ~load_d;
    assign start_ev = start_s2 & ~start_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_s1  <= 1'b0;
            load_s2  <= 1'b0;
            load_d   <= 1'b0;
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_d  <= 1'b0;
        end else begin
            load_s1  <= load;
            load_s2  <= load_s1;
            load_d   <= load_s2;
            start_s1 <= start;
            start_s2 <= start_s1;
            start_d  <= start_s2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tens    <= 4'd0;
            ones    <= 4'd0;
            div     <= '0;
            done    <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_n;
            tens    <= tens_n;
            ones    <= ones_n;
            div     <= div_n;
            done    <= (state_n == DONE);
            running <= (state_n == RUN);
        end
    end

    // Priority: load, then start toggle, then the RUN tick. A start toggle out
    // of RUN freezes the divider for that cycle as well.
    always_comb begin
        state_n = state;
        tens_n  = tens;
        ones_n  = ones;
        div_n   = div;
        if (load_ev) begin
            tens_n  = (preset_tens > 4'd9) ? 4'd9 : preset_tens;
            ones_n  = (preset_ones > 4'd9) ? 4'd9 : preset_ones;
            div_n   = '0;
            state_n = IDLE;
        end else if (start_ev) begin
            unique case (state)
                IDLE: begin
                    div_n = '0;
                    if (tens == 4'd0 && ones == 4'd0) state_n = DONE;
                    else                              state_n = RUN;
                end
                RUN:   state_n = PAUSE;
                PAUSE: state_n = RUN;
                DONE:  state_n = DONE;
            endcase
        end else if (state == RUN) begin
            if (div == DIV_MAX) begin
                div_n = '0;
                if (ones != 4'd0) begin
                    ones_n = ones - 4'd1;
                end else begin
                    ones_n = 4'd9;
                    tens_n = tens - 4'd1;
                end
                // RUN is only ever entered with a nonzero value, so 01 is
                // the last step and the count cannot wrap.
                if (tens == 4'd0 && ones == 4'd1) state_n = DONE;
            end else begin
                div_n = div + 1'b1;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign seg0 = seg7(ones);
    assign seg1 = seg7(tens);

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int TICK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic [3:0] preset_tens = 4'd0;
    logic [3:0] preset_ones = 4'd0;
    logic [6:0] seg0, seg1;
    logic       done, running;

    countdown_timer #(.TICK_DIV(TICK), .DIV_W(3)) dut (
        .clk(clk), .rst(rst), .load(load), .start(start),
        .preset_tens(preset_tens), .preset_ones(preset_ones),
        .seg0(seg0), .seg1(seg1), .done(done), .running(running)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    typedef struct {
        int value;
        bit is_done;
        bit is_run;
    } exp_t;

    exp_t q[$];

    // Reference model: a plain integer 0..99, a mode word and a count of RUN
    // cycles since the last step. Button events are taken from the raw input
    // history: sampled high two edges ago and low three edges ago.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_value, m_mode, m_acc;
    bit hl[3], hs[3];

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_value = 0; m_mode = M_IDLE; m_acc = 0;
        for (int i = 0; i < 3; i++) begin hl[i] = 0; hs[i] = 0; end
    endtask

    function automatic int clamp9(input int v);
        return (v > 9) ? 9 : v;
    endfunction

    task automatic model_edge();
        bit ld_ev, st_ev;
        ld_ev = hl[1] && !hl[2];
        st_ev = hs[1] && !hs[2];
        if (ld_ev) begin
            m_value = clamp9(int'(preset_tens)) * 10 + clamp9(int'(preset_ones));
            m_mode  = M_IDLE;
            m_acc   = 0;
        end else if (st_ev) begin
            case (m_mode)
                M_IDLE:  begin m_acc = 0; m_mode = (m_value != 0) ? M_RUN : M_DONE; end
                M_RUN:   m_mode = M_PAUSE;
                M_PAUSE: m_mode = M_RUN;
                default: ;
            endcase
        end else if (m_mode == M_RUN) begin
            m_acc++;
            if (m_acc == TICK) begin
                m_acc = 0;
                m_value--;
                if (m_value == 0) m_mode = M_DONE;
            end
        end
        hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = load;
        hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = start;
    endtask

    // One clock: drive inputs on the falling edge, predict the next rising
    // edge, and queue the prediction for the monitor.
    task automatic step(input bit ld, input bit st);
        exp_t e;
        @(negedge clk);
        load = ld;
        start = st;
        model_edge();
        e.value = m_value;
        e.is_done = (m_mode == M_DONE);
        e.is_run = (m_mode == M_RUN);
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic do_load(input int t, input int o);
        preset_tens = 4'(t);
        preset_ones = 4'(o);
        step(1, 0);
        idle(3);
    endtask

    task automatic do_start();
        step(0, 1);
        idle(2);
    endtask

    always @(negedge clk) begin
        if (rst && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("seg1", int'(seg1), int'(seg_tab[e.value / 10]));
            chk("seg0", int'(seg0), int'(seg_tab[e.value % 10]));
            chk("done", int'(done), int'(e.is_done));
            chk("running", int'(running), int'(e.is_run));
        end
    end

    initial begin
        model_reset();
        #12;
        chk("rst_seg0", int'(seg0), 7'b1000000);
        chk("rst_seg1", int'(seg1), 7'b1000000);
        chk("rst_done", int'(done), 0);
        chk("rst_running", int'(running), 0);
        @(negedge clk);
        rst = 1'b1;

        // 10 -> 09 borrow
        do_load(1, 0);
        do_start();
        idle(6);
        // 03 down to 00, then hold
        do_load(0, 3);
        do_start();
        idle(16);
        idle(20);
        // pause / resume, divider frozen
        do_load(0, 5);
        step(0, 1);
        idle(7);
        step(0, 1);
        idle(12);
        step(0, 1);
        idle(6);
        // clamped preset, then zero preset
        do_load(15, 12);
        do_load(0, 0);
        do_start();
        idle(3);
        // load and start together mid-run, then held start
        do_load(2, 2);
        do_start();
        idle(5);
        step(1, 1);
        idle(4);
        for (int i = 0; i < 50; i++) step(0, 1);
        idle(10);

        // asynchronous reset mid-run at value 07
        do_load(0, 8);
        do_start();
        while (m_value != 7) step(0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_seg0", int'(seg0), 7'b1000000);
        chk("arst_seg1", int'(seg1), 7'b1000000);
        chk("arst_done", int'(done), 0);
        chk("arst_running", int'(running), 0);
        load = 1'b0;
        start = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // random phase
        for (int i = 0; i < 3000; i++) begin
            bit ld, st;
            if ($urandom_range(0, 19) == 0) begin
                preset_tens = 4'($urandom_range(0, 15));
                preset_ones = 4'($urandom_range(0, 15));
            end
            ld = ($urandom_range(0, 59) == 0);
            st = ($urandom_range(0, 14) == 0) || (start && $urandom_range(0, 3) != 0);
            step(ld, st);
        end

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Two-digit BCD countdown timer, the down-counting counterpart of the existing 00→99 up-counter display block. It loads a preset from switches, counts down once per TICK_DIV clock cycles under start/pause control, stops at 00 and flags completion. It drives two active-low seven-segment digits: seg0 shows ones, seg1 shows tens.

Parameters:
TICK_DIV, 50000000, clock cycles per count step (1 s at 50 MHz); must be ≥ 2.
DIV_W, 33, width of the internal divider counter; must hold TICK_DIV-1.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-low reset
load  input  1  asynchronous button/switch; rising edge loads preset
start  input  1  asynchronous button/switch; rising edge toggles start/pause
preset_tens  input  4  BCD tens digit to load
preset_ones  input  4  BCD ones digit to load
seg0  output  7  ones digit, active-low, bit0=A … bit6=G
seg1  output  7  tens digit, active-low, bit0=A … bit6=G
done  output  1  high while in DONE
running  output  1  high while in RUN

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, tens=ones=0, divider=0, sync and edge registers=0, done=0, running=0, seg0=seg1=7'b1000000 (shows "00").
- load and start each pass through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~sync2_d). An input first sampled high at edge N takes effect at edge N+2. A held level produces exactly one event.
- States: IDLE, RUN, PAUSE, DONE. done and running are registered outputs that track the state.
- load event (any state): tens←min(preset_tens,9), ones←min(preset_ones,9), divider←0, state←IDLE. load beats start in the same cycle; the start event is dropped.
- start event:
  - IDLE, value≠00 → RUN, divider←0.
  - IDLE, value=00 → DONE.
  - RUN → PAUSE; divider and digits hold.
  - PAUSE → RUN; divider resumes from its held value.
  - DONE → ignored.
- RUN: the divider increments every cycle. When divider==TICK_DIV-1: divider←0 and the value decrements.
  - ones≠0: ones←ones-1.
  - ones=0: ones←9, tens←tens-1 (borrow).
  - If the value before the decrement was 01, the state moves to DONE on the same edge as the 00 value.
- DONE: value holds at 00, divider holds at 0, done=1 until the next load.
- The value never wraps below 00. Digits are always in 0-9.
- Display: combinational decode of the digit registers. Active-low patterns, G..A:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset mid-operation: an immediate return to the reset state, regardless of state or divider.

Test Plan:
- TICK_DIV=4. Assert rst; release; load preset 1,0 → seg1=1111001, seg0=1000000, state IDLE, done=0. Pulse start → running=1. After 4 RUN cycles, value 09: seg1=1000000, seg0=0010000 (borrow checked).
- Preset 0,3, start, let it run → 03→02→01→00 at 4-cycle intervals. done rises on the same edge as 00. running=0, and the value stays 00 for 20 more cycles.
- Preset 0,5, start, pause after 6 cycles → value 04, divider frozen. After a 10-cycle wait the value is still 04. Restart → 03 exactly 2 cycles after resume.
- Preset 15,12 (invalid) → loaded as 9,9: seg1=seg0=0010000. Preset 0,0 then start → DONE immediately, done=1.
- load and start rise in the same cycle during RUN → value reloads, state IDLE, running=0. Holding start high for 50 cycles → only one toggle.
- Assert rst mid-RUN at value 07 → outputs go to reset values asynchronously, before the next clk edge: seg0=seg1=1000000, done=0, running=0.
